dram_cmd_arbiter: RTL

Command-bus arbiter between the per-bank FSMs and the DDR3 command/address pins. Each cycle it selects at most one pending bank command (ACTIVE, READ, WRITE, PRECHARGE) by round-robin among timing-legal requesters. It enforces the bus-level spacing rules tRRD, tCCD, tWTR and tRTW. It also sequences all-bank refresh: drain, issue, then a tRFC hold-off.

---
 rtl/dram_cmd_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_arbiter.sv
// Command-bus arbiter: round-robin choice among timing-legal bank requests,
// bus spacing (tRRD/tCCD/tWTR/tRTW) and all-bank refresh sequencing.
module dram_cmd_arbiter #(
  parameter int NUM_BANK = 8,
  parameter int T_RRD    = 4,
  parameter int T_CCD    = 4,
  parameter int T_WTR    = 6,
  parameter int T_RTW    = 5,
  parameter int T_RFC    = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANK-1:0]           req_valid,
  input  logic [NUM_BANK*4-1:0]         req_cmd,
  input  logic [NUM_BANK*14-1:0]        req_row,
  input  logic [NUM_BANK*14-1:0]        req_col,
  output logic [NUM_BANK-1:0]           req_gnt,
  input  logic                          ref_req,
  input  logic                          all_idle,
  output logic                          ref_gnt,
  output logic                          dram_cmd_valid,
  output logic [3:0]                    dram_cmd,
  output logic [$clog2(NUM_BANK)-1:0]   dram_bank,
  output logic [13:0]                   dram_row,
  output logic [13:0]                   dram_col
);

  localparam int BW = $clog2(NUM_BANK);

  localparam logic [3:0] ATCMD_NOP       = 4'h0;
  localparam logic [3:0] ATCMD_ACTIVE    = 4'h1;
  localparam logic [3:0] ATCMD_READ      = 4'h2;
  localparam logic [3:0] ATCMD_WRITE     = 4'h3;
  localparam logic [3:0] ATCMD_PRECHARGE = 4'h4;
  localparam logic [3:0] ATCMD_REFRESH   = 4'h5;

  localparam logic [3:0] RRD_LD = 4'(T_RRD - 1);
  localparam logic [3:0] CCD_LD = 4'(T_CCD - 1);
  localparam logic [3:0] WTR_LD = 4'(T_WTR - 1);
  localparam logic [3:0] RTW_LD = 4'(T_RTW - 1);
  localparam logic [3:0] RFC_LD = 4'(T_RFC - 1);

  typedef enum logic [1:0] {S_NORM, S_DRAIN, S_RFC} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [3:0]      rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d, rtw_q, rtw_d, rfc_q, rfc_d;
  logic            vld_q, vld_d;
  logic [3:0]      cmd_q, cmd_d;
  logic [BW-1:0]   bank_q, bank_d;
  logic [13:0]     row_q, row_d, col_q, col_d;

  logic [NUM_BANK-1:0] elig;
  logic [3:0]      bcmd;
  logic            bank_ok;
  logic            found;
  logic [BW-1:0]   gnt_idx;
  logic [3:0]      gnt_cmd;
  int              idx;
  int              sel;

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  // Eligibility and round-robin selection
  always_comb begin
    elig = '0;
    bcmd = ATCMD_NOP;
    for (int i = 0; i < NUM_BANK; i++) begin
      bcmd = req_cmd[4*i +: 4];
      case (bcmd)
        ATCMD_ACTIVE:    elig[i] = req_valid[i] && (rrd_q == 4'd0) && (state_q == S_NORM);
        ATCMD_READ:      elig[i] = req_valid[i] && (ccd_q == 4'd0) && (wtr_q == 4'd0);
        ATCMD_WRITE:     elig[i] = req_valid[i] && (ccd_q == 4'd0) && (rtw_q == 4'd0);
        ATCMD_PRECHARGE: elig[i] = req_valid[i];
        default:         elig[i] = 1'b0;
      endcase
    end
    ref_gnt = !rst && (state_q == S_DRAIN) && all_idle;
    bank_ok = !rst && (state_q != S_RFC) && !ref_gnt;

    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_BANK; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_BANK;
      if (!found && bank_ok && elig[idx]) begin
        found   = 1'b1;
        gnt_idx = BW'(idx);
      end
    end
    req_gnt = '0;
    if (found) req_gnt[gnt_idx] = 1'b1;
    sel     = int'(gnt_idx);
    gnt_cmd = req_cmd[4*sel +: 4];
  end

  // Next-state: FSM, spacing counters, pointer and output register
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    rrd_d    = sat_dec(rrd_q);
    ccd_d    = sat_dec(ccd_q);
    wtr_d    = sat_dec(wtr_q);
    rtw_d    = sat_dec(rtw_q);
    rfc_d    = ref_gnt ? RFC_LD : sat_dec(rfc_q);
    vld_d    = 1'b0;
    cmd_d    = ATCMD_NOP;
    bank_d   = '0;
    row_d    = '0;
    col_d    = '0;

    case (state_q)
      S_NORM:  if (ref_req) state_d = S_DRAIN;
      // Leave S_RFC as the counter reaches zero so the first grant lands
      // exactly T_RFC cycles after ref_gnt.
      S_DRAIN: if (all_idle) state_d = (T_RFC == 1) ? S_NORM : S_RFC;
      S_RFC:   if (rfc_q <= 4'd1) state_d = S_NORM;
      default: state_d = S_NORM;
    endcase

    if (found) begin
      rr_ptr_d = (gnt_idx == BW'(NUM_BANK - 1)) ? '0 : gnt_idx + 1'b1;
      case (gnt_cmd)
        ATCMD_ACTIVE: rrd_d = RRD_LD;
        ATCMD_READ: begin
          ccd_d = CCD_LD;
          rtw_d = RTW_LD;
        end
        ATCMD_WRITE: begin
          ccd_d = CCD_LD;
          wtr_d = WTR_LD;
        end
        default: ;
      endcase
      vld_d  = 1'b1;
      cmd_d  = gnt_cmd;
      bank_d = gnt_idx;
      row_d  = req_row[14*sel +: 14];
      col_d  = req_col[14*sel +: 14];
    end else if (ref_gnt) begin
      vld_d = 1'b1;
      cmd_d = ATCMD_REFRESH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_NORM;
      rr_ptr_q <= '0;
      rrd_q    <= '0;
      ccd_q    <= '0;
      wtr_q    <= '0;
      rtw_q    <= '0;
      rfc_q    <= '0;
      vld_q    <= 1'b0;
      cmd_q    <= ATCMD_NOP;
      bank_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rrd_q    <= rrd_d;
      ccd_q    <= ccd_d;
      wtr_q    <= wtr_d;
      rtw_q    <= rtw_d;
      rfc_q    <= rfc_d;
      vld_q    <= vld_d;
      cmd_q    <= cmd_d;
      bank_q   <= bank_d;
      row_q    <= row_d;
      col_q    <= col_d;
    end
  end

  assign dram_cmd_valid = vld_q;
  assign dram_cmd       = cmd_q;
  assign dram_bank      = bank_q;
  assign dram_row       = row_q;
  assign dram_col       = col_q;

endmodule
